// File: rtl/bcd_divisibility_checker_if.sv
// bcd_divisibility_checker_if: digit stream in, one held-until-taken divisibility result out
interface bcd_divisibility_checker_if;
    logic       digit_valid;
    logic       digit_ready;
    logic [3:0] digit;
    logic       last;
    logic       result_valid;
    logic       result_ready;
    logic       divisible;
    logic [3:0] remainder;
    logic       bad_digit;
    logic       overflow;
    modport master (
        output digit_valid, digit, last, result_ready,
        input  digit_ready, result_valid, divisible, remainder, bad_digit, overflow
    );
    modport slave (
        input  digit_valid, digit, last, result_ready,
        output digit_ready, result_valid, divisible, remainder, bad_digit, overflow
    );
endinterface

// File: rtl/bcd_divisibility_checker.sv
// bcd_divisibility_checker: streaming MSD-first BCD number mod DIVISOR with bad-digit/overflow flags
module bcd_divisibility_checker #(
    parameter int DIVISOR    = 4,
    parameter int MAX_DIGITS = 4
) (
    input logic                          clk,
    input logic                          rst_n,
    bcd_divisibility_checker_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;
    state_t     state_q, state_d;
    logic [3:0] r_q, r_d, cnt_q, cnt_d, rem_q, rem_d;
    logic       bad_q, bad_d, ovf_q, ovf_d, rbad_q, rbad_d, rovf_q, rovf_d;
    logic       accept;
    logic [7:0] prod;
    assign bus.digit_ready  = state_q != RESULT;
    assign bus.result_valid = state_q == RESULT;
    assign bus.remainder    = rem_q;
    assign bus.bad_digit    = rbad_q;
    assign bus.overflow     = rovf_q;
    assign bus.divisible    = bus.result_valid && rem_q == 4'd0 && !rbad_q;
    assign accept           = bus.digit_valid && bus.digit_ready;
    assign prod             = 8'(r_q) * 8'd10 + 8'(bus.digit);
    // Accumulators restart on the Last digit; the result registers hold until consumed.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        ovf_d   = ovf_q;
        rem_d   = rem_q;
        rbad_d  = rbad_q;
        rovf_d  = rovf_q;
        if (accept) begin
            r_d     = 4'(prod % 8'(DIVISOR));
            cnt_d   = cnt_q == 4'd15 ? 4'd15 : cnt_q + 4'd1;
            bad_d   = bad_q | (bus.digit > 4'd9);
            ovf_d   = ovf_q | (cnt_q == 4'(MAX_DIGITS));
            state_d = bus.last ? RESULT : ACCUM;
            if (bus.last) begin
                rem_d  = r_d;
                rbad_d = bad_d;
                rovf_d = ovf_d;
                r_d    = 4'd0;
                cnt_d  = 4'd0;
                bad_d  = 1'b0;
                ovf_d  = 1'b0;
            end
        end
        if (state_q == RESULT && bus.result_ready) begin
            state_d = IDLE;
            rem_d   = 4'd0;
            rbad_d  = 1'b0;
            rovf_d  = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= 4'd0;
            cnt_q   <= 4'd0;
            bad_q   <= 1'b0;
            ovf_q   <= 1'b0;
            rem_q   <= 4'd0;
            rbad_q  <= 1'b0;
            rovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
            rbad_q  <= rbad_d;
            rovf_q  <= rovf_d;
        end
    end
endmodule

// File: tb/tb_bcd_divisibility_checker.sv
// tb_bcd_divisibility_checker: directed scenarios on a divide-by-4 and a divide-by-7 instance
module tb_bcd_divisibility_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bcd_divisibility_checker_if a4();
    bcd_divisibility_checker_if a7();
    bcd_divisibility_checker #(.DIVISOR(4), .MAX_DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(a4.slave));
    bcd_divisibility_checker #(.DIVISOR(7), .MAX_DIGITS(4)) dut7 (.clk(clk), .rst_n(rst_n), .bus(a7.slave));
    always #5 clk = ~clk;

    // sel=0 drives the /4 instance, sel=1 the /7 instance; returns at the negedge after acceptance
    task automatic send(input bit sel, input logic [3:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        if (sel) begin a7.digit_valid = 1; a7.digit = d; a7.last = l; end
        else begin a4.digit_valid = 1; a4.digit = d; a4.last = l; end
        while (!(sel ? a7.digit_ready : a4.digit_ready) && n < 20) begin @(negedge clk); n++; end
        if (!(sel ? a7.digit_ready : a4.digit_ready)) begin
            tests++; fails++;
            $display("FAIL send_timeout: digit_ready got 0 want 1 (sel=%0d digit=%0d)", sel, d);
        end
        @(negedge clk);
        if (sel) a7.digit_valid = 0; else a4.digit_valid = 0;
    endtask

    task automatic consume(input bit sel);
        @(negedge clk);
        if (sel) a7.result_ready = 1; else a4.result_ready = 1;
        @(negedge clk);
        if (sel) a7.result_ready = 0; else a4.result_ready = 0;
    endtask

    task automatic test_reset;
        tests++;
        if ({a4.digit_ready, a4.result_valid, a4.divisible, a4.remainder, a4.bad_digit, a4.overflow} !== 9'b1_0_0_0000_0_0) begin
            fails++;
            $display("FAIL reset_state: got %b want 100000000",
                     {a4.digit_ready, a4.result_valid, a4.divisible, a4.remainder, a4.bad_digit, a4.overflow});
        end
    endtask

    task automatic test_basic;
        send(0, 4'd9, 0);
        send(0, 4'd6, 1);
        tests++;
        if ({a4.result_valid, a4.divisible, a4.remainder, a4.bad_digit, a4.overflow} !== 8'b1_1_0000_0_0) begin
            fails++;
            $display("FAIL basic_96: got %b want 11000000",
                     {a4.result_valid, a4.divisible, a4.remainder, a4.bad_digit, a4.overflow});
        end
        consume(0);
        tests++;
        if (a4.result_valid !== 1'b0) begin
            fails++; $display("FAIL basic_consumed: result_valid got %b want 0", a4.result_valid);
        end
    endtask

    task automatic test_hold;
        send(0, 4'd7, 0);
        send(0, 4'd4, 1);
        a4.digit_valid = 1; a4.digit = 4'd0; a4.last = 1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({a4.result_valid, a4.divisible, a4.remainder, a4.digit_ready} !== 7'b1_0_0010_0) begin
                fails++;
                $display("FAIL hold_74 cycle %0d: got %b want 1000100", i,
                         {a4.result_valid, a4.divisible, a4.remainder, a4.digit_ready});
            end
            @(negedge clk);
        end
        a4.result_ready = 1;
        @(negedge clk);
        a4.result_ready = 0;
        tests++;
        if ({a4.result_valid, a4.digit_ready} !== 2'b01) begin
            fails++; $display("FAIL hold_idle: {valid,ready} got %b want 01", {a4.result_valid, a4.digit_ready});
        end
        @(negedge clk);
        a4.digit_valid = 0;
        tests++;
        if ({a4.result_valid, a4.divisible, a4.remainder} !== 6'b1_1_0000) begin
            fails++; $display("FAIL hold_stalled_0: got %b want 110000", {a4.result_valid, a4.divisible, a4.remainder});
        end
        consume(0);
    endtask

    task automatic test_back_to_back;
        a4.result_ready = 1;
        send(0, 4'd0, 1);
        tests++;
        if ({a4.result_valid, a4.divisible, a4.remainder} !== 6'b1_1_0000) begin
            fails++; $display("FAIL b2b_0: got %b want 110000", {a4.result_valid, a4.divisible, a4.remainder});
        end
        a4.digit_valid = 1; a4.digit = 4'd8; a4.last = 1;
        tests++;
        if (a4.digit_ready !== 1'b0) begin
            fails++; $display("FAIL b2b_stall: digit_ready got %b want 0", a4.digit_ready);
        end
        @(negedge clk);
        tests++;
        if ({a4.result_valid, a4.digit_ready} !== 2'b01) begin
            fails++; $display("FAIL b2b_bubble: {valid,ready} got %b want 01", {a4.result_valid, a4.digit_ready});
        end
        @(negedge clk);
        a4.digit_valid = 0;
        tests++;
        if ({a4.result_valid, a4.divisible, a4.remainder} !== 6'b1_1_0000) begin
            fails++; $display("FAIL b2b_8: got %b want 110000", {a4.result_valid, a4.divisible, a4.remainder});
        end
        @(negedge clk);
        a4.result_ready = 0;
    endtask

    task automatic test_div7;
        send(1, 4'd1, 0); send(1, 4'd0, 0); send(1, 4'd0, 0); send(1, 4'd1, 1);
        tests++;
        if ({a7.result_valid, a7.divisible, a7.remainder, a7.overflow} !== 7'b1_1_0000_0) begin
            fails++; $display("FAIL div7_1001: got %b want 1100000", {a7.result_valid, a7.divisible, a7.remainder, a7.overflow});
        end
        consume(1);
        for (int i = 1; i <= 5; i++) send(1, 4'(i), i == 5);
        tests++;
        if ({a7.result_valid, a7.divisible, a7.remainder, a7.overflow} !== 7'b1_0_0100_1) begin
            fails++; $display("FAIL div7_12345: got %b want 1001001", {a7.result_valid, a7.divisible, a7.remainder, a7.overflow});
        end
        consume(1);
    endtask

    task automatic test_bad_digit;
        send(0, 4'd1, 0);
        send(0, 4'd10, 1);
        tests++;
        if ({a4.result_valid, a4.divisible, a4.remainder, a4.bad_digit} !== 7'b1_0_0000_1) begin
            fails++; $display("FAIL bad_1A: got %b want 1000001", {a4.result_valid, a4.divisible, a4.remainder, a4.bad_digit});
        end
        consume(0);
        send(0, 4'd1, 0);
        send(0, 4'd2, 1);
        tests++;
        if ({a4.result_valid, a4.divisible, a4.remainder, a4.bad_digit} !== 7'b1_1_0000_0) begin
            fails++; $display("FAIL bad_cleared_12: got %b want 1100000", {a4.result_valid, a4.divisible, a4.remainder, a4.bad_digit});
        end
        consume(0);
    endtask

    task automatic test_reset_mid;
        send(0, 4'd3, 0);
        send(0, 4'd5, 0);
        #1 rst_n = 0;
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        tests++;
        if (a4.result_valid !== 1'b0) begin
            fails++; $display("FAIL reset_mid_no_result: result_valid got %b want 0", a4.result_valid);
        end
        send(0, 4'd1, 0);
        send(0, 4'd6, 1);
        tests++;
        if ({a4.result_valid, a4.divisible, a4.remainder} !== 6'b1_1_0000) begin
            fails++; $display("FAIL reset_mid_16: got %b want 110000", {a4.result_valid, a4.divisible, a4.remainder});
        end
        consume(0);
    endtask

    initial begin
        a4.digit_valid = 0; a4.digit = 0; a4.last = 0; a4.result_ready = 0;
        a7.digit_valid = 0; a7.digit = 0; a7.last = 0; a7.result_ready = 0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1;
        test_basic();
        test_hold();
        test_back_to_back();
        test_div7();
        test_bad_digit();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bcd_divisibility_checker.md
# bcd_divisibility_checker

Streaming, parametrised divisibility checker for unsigned BCD numbers of arbitrary length. Digits arrive one per handshake, most-significant first. A running remainder modulo `DIVISOR` is folded in per digit, and one result per number is presented on a held-until-taken output handshake. The block replaces fixed two-digit, divide-by-four combinational checks wherever digits are produced serially, such as keypad or UART digit streams.

## Interface
- `DIVISOR`, default 4: constant divisor, legal range 2..15.
- `MAX_DIGITS`, default 4: expected maximum digits per number, legal range 1..15. Used only for the overflow flag.
- `Clock` in 1: single clock; all state changes on the rising edge.
- `Reset_N` in 1: asynchronous, active-low reset.
- `DigitValid` in 1: `Digit` and `Last` are valid.
- `DigitReady` out 1: block can accept a digit.
- `Digit` in 4: BCD digit; values 10..15 are illegal.
- `Last` in 1: this digit is the least-significant digit of the number.
- `ResultValid` out 1: result outputs are valid.
- `ResultReady` in 1: consumer takes the result.
- `Divisible` out 1: the number is divisible by `DIVISOR` and contains no illegal digit.
- `Remainder` out 4: number mod `DIVISOR`, zero-extended.
- `BadDigit` out 1: at least one digit in the number was greater than 9.
- `Overflow` out 1: more than `MAX_DIGITS` digits were accepted for this number.

## Operation
- States:
  - IDLE: no digit accepted yet for the current number.
  - ACCUM: at least one digit accepted, `Last` not yet seen.
  - RESULT: result held on the outputs.
- `DigitReady = 1` in IDLE and ACCUM, 0 in RESULT.
- A digit is accepted when `DigitValid & DigitReady` at a rising edge.
- Remainder update on acceptance: `r_next = (r*10 + Digit) mod DIVISOR`.
  - `r` resets to 0 at the start of every number.
  - The intermediate value is at most 14*10 + 15 = 155, so it is 8 bits wide.
  - The raw 4-bit digit value is used, even when illegal.
- Digit counter: 4 bits, saturating at 15, cleared at the start of every number.
- `Overflow` sets when a digit is accepted while the count already equals `MAX_DIGITS`. It is sticky until the number's result is consumed.
- `BadDigit` sets when any accepted digit is greater than 9. It is sticky until the number's result is consumed.
- Transitions:
  - IDLE, on accept with `Last=0`: go to ACCUM.
  - IDLE or ACCUM, on accept with `Last=1`: go to RESULT. The outputs load the final remainder and flags in the same edge.
  - ACCUM, on accept with `Last=0`: stay in ACCUM.
  - RESULT, when `ResultReady=1`: go to IDLE, clearing `r`, the counter and both flags.
- `Divisible = (Remainder == 0) & ~BadDigit`.
- A single-digit number (`Last` set on the first digit) is legal. An empty number is not representable.

## Timing
- Reset values: state IDLE, `DigitReady=1`, `ResultValid=0`, `Divisible=0`, `Remainder=0`, `BadDigit=0`, `Overflow=0`. Internal remainder and counter are 0.
- Result latency: `ResultValid` rises on the edge that accepts the `Last` digit, so results are visible in the following cycle.
- Result hold: `ResultValid`, `Divisible`, `Remainder`, `BadDigit` and `Overflow` stay stable while `ResultValid=1` and `ResultReady=0`.
- Back-to-back numbers: if `ResultReady` is held high, RESULT lasts exactly one cycle. The next digit can be accepted in the cycle after RESULT, giving a one-cycle bubble per number.
- Stalled digits: `DigitValid` asserted during RESULT is stalled, not dropped. The digit is accepted once the block returns to IDLE.
- `ResultReady` outside RESULT has no effect.
- Reset mid-number or mid-RESULT: state, remainder, counter, flags and outputs clear immediately. The partial number is discarded with no result produced.
- Throughput: at most one digit per cycle.

## Test plan
- `DIVISOR=4`, digits 9 then 6 with `Last`: the cycle after, `ResultValid=1`, `Divisible=1`, `Remainder=0`, `BadDigit=0`, `Overflow=0`.
- `DIVISOR=4`, digits 7 then 4 with `Last`, `ResultReady` low for 3 cycles while the next digit 0 is driven with `DigitValid=1`: `Remainder=2` and `Divisible=0` are held stable, and `DigitReady=0`. After `ResultReady` is pulsed, the digit 0 is accepted the cycle after return to IDLE.
- `DIVISOR=4`, single digit 0 with `Last`: `Divisible=1`, `Remainder=0`. Then single digit 8 back-to-back with `ResultReady` tied high: `Divisible=1`, with a one-cycle bubble between accepts.
- `DIVISOR=7`, `MAX_DIGITS=4`:
  - Digits 1,0,0,1 (1001 = 7 × 143): `Divisible=1`, `Overflow=0`.
  - Then digits 1,2,3,4,5: `Overflow=1`, `Remainder=4`, `Divisible=0`.
- `DIVISOR=4`, digits 1 then 10 (illegal) with `Last`: `BadDigit=1`, `Remainder=0` (1*10 + 10 = 20), `Divisible=0`. The next number, 1 then 2, gives `BadDigit=0`, `Divisible=1`.
- `Reset_N` asserted after digits 3,5 without `Last`: all outputs return to reset values immediately and no result is produced. The number 1 then 6 afterwards gives `Divisible=1`, `Remainder=0`.
